dispatcher_collect: RTL and testbench
=====================================

# dispatcher_collect

Return-path receiver for the dispatcher. It accepts packets that CPU threads send back over the RDMA channel, using the standard packet/valid two-FIFO interface, and buffers them. It discards packets flagged invalid, forwards kept packets to egress, and returns each thread's allocation credit to the cpuid allocator. It sits between the RDMA return port and the egress pipeline.

## Interface
- PKT_DEPTH, 256: packet-word FIFO depth (power of 2).
- VAL_DEPTH, 64: valid-flag FIFO depth (power of 2).
- PKT_MAX_WORDS, 32: largest packet in words; sets the almostfull margin.
- CPUID_LSB, 64: LSB of the 5-bit cpuid field in the head word.
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- in_rdma_pkt_wr  in  1  packet word write strobe.
- in_rdma_pkt  in  134  packet word: [133:132] type (01 head, 11 body, 10 tail), [131:128] invalid-byte count, [127:0] data.
- in_rdma_valid_wr  in  1  per-packet flag write, issued after the tail word.
- in_rdma_valid  in  1  1 = keep, 0 = drop.
- out_rdma_pkt_almostfull  out  1  backpressure to the RDMA side.
- out_egress_pkt_wr  out  1  egress word strobe.
- out_egress_pkt  out  134  egress word, passed through unmodified.
- out_egress_valid_wr  out  1  egress flag strobe.
- out_egress_valid  out  1  egress flag; always 1 when written.
- in_egress_pkt_almostfull  in  1  egress backpressure.
- out_cpuid_release  out  1  one-cycle credit-return pulse.
- out_cpuid_release_id  out  5  thread id being released.
- out_drop_cnt  out  32  packets discarded.
- out_err_cnt  out  32  framing errors.

## Operation
- Input side:
  - Every in_rdma_pkt_wr word is written to the packet FIFO.
  - Every in_rdma_valid_wr flag is written to the valid FIFO.
  - Both FIFOs are show-ahead.
- out_rdma_pkt_almostfull = (pkt usedw ≥ PKT_DEPTH − PKT_MAX_WORDS) OR (val usedw ≥ VAL_DEPTH − 2).
- Read FSM states: IDLE, FORWARD, DISCARD.
- IDLE:
  - Waits for the valid FIFO to be non-empty.
  - If the flag is 1, it also waits for in_egress_pkt_almostfull = 0, then pops the flag and goes to FORWARD.
  - If the flag is 0, it pops the flag and goes to DISCARD regardless of egress state.
- FORWARD:
  - Pops one word per cycle and registers it onto out_egress_pkt with out_egress_pkt_wr = 1.
  - On the tail word (type 10), it also asserts out_egress_valid_wr = 1 and out_egress_valid = 1 on the same output cycle, then returns to IDLE.
  - Egress almostfull is ignored mid-packet; downstream margin covers PKT_MAX_WORDS.
- DISCARD:
  - Pops one word per cycle with no egress output.
  - On the tail word it increments out_drop_cnt and returns to IDLE.
- Credit release:
  - The first word popped in FORWARD or DISCARD is the head word.
  - On that pop, out_cpuid_release pulses for one cycle and out_cpuid_release_id = head[CPUID_LSB+4:CPUID_LSB].
- Framing errors:
  - A first popped word whose type is not 01 increments out_err_cnt.
  - A type-01 word popped after the first word of a packet also increments out_err_cnt.
  - Processing is otherwise unchanged; only a type-10 word ends a packet.
- Counters saturate at 32'hFFFF_FFFF.
- Simultaneous input writes and FSM reads are legal in any cycle.

## Timing
- Reset values: all outputs 0; FSM in IDLE; FIFOs empty; counters 0.
- Reset mid-packet aborts the packet. No egress valid is written for it and no further words of it appear.
- Latency for an empty block: valid flag written in cycle N.
  - N+1: the flag is visible and IDLE pops it.
  - N+2: the head word is popped.
  - N+3: out_egress_pkt_wr is asserted for the head.
- Release pulse is in cycle N+3, aligned with the head's output cycle.
- Throughput: one word per cycle inside a packet.
- There is one IDLE cycle between packets.

## Structure
- A shared package holds:
  - word-type constants (HEAD 2'b01, BODY 2'b11, TAIL 2'b10);
  - the state enum;
  - the 134-bit word width.
- One sub-module, collect_fifo, is a parameterised show-ahead FIFO with usedw output. It is instantiated twice: 134-bit × PKT_DEPTH and 1-bit × VAL_DEPTH.
- The FSM, counters and output registers live in the top module.

## Test plan
- Keep packet:
  - Stimulus: 4-word packet (head cpuid = 5'd7, two body words, tail), then valid = 1.
  - Response: 4 egress words identical to input; egress valid = 1 on the tail cycle; one release pulse with id 7; first egress word 3 cycles after valid_wr.
- Drop packet:
  - Stimulus: 3-word packet with cpuid 5'd3, then valid = 0.
  - Response: no egress activity; drop_cnt = 1; one release pulse with id 3.
- Egress backpressure:
  - Stimulus: hold in_egress_pkt_almostfull = 1 with a kept packet queued.
  - Response: no pop. Deassert → packet emitted. Assert mid-packet → packet still completes.
- Input almostfull:
  - Stimulus: write 224 words with egress blocked.
  - Response: out_rdma_pkt_almostfull = 1 at usedw 224; deasserts as the FIFO drains.
- Framing error:
  - Stimulus: head, head, tail, then valid = 1.
  - Response: err_cnt = 1; 3 words forwarded; one release pulse.
- Reset:
  - Stimulus: assert reset mid-FORWARD.
  - Response: all outputs 0 immediately; counters 0; next packet processed normally.

Source files
------------

// File: rtl/dispatcher_collect_pkg.sv
// Shared definitions for the dispatcher return-path collector:
// packet word layout, word-type codes and read FSM states.
package dispatcher_collect_pkg;

   localparam int unsigned WORD_W = 134;

   localparam logic [1:0] TYPE_HEAD = 2'b01;
   localparam logic [1:0] TYPE_BODY = 2'b11;
   localparam logic [1:0] TYPE_TAIL = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FORWARD,
      ST_DISCARD
   } state_t;

   function automatic logic [1:0] word_type(input logic [WORD_W-1:0] w);
      return w[WORD_W-1 -: 2];
   endfunction

endpackage

// File: rtl/collect_fifo.sv
// Show-ahead FIFO: q always presents the oldest entry while not empty.
// usedw is one bit wider than the address so a full FIFO reads as DEPTH.
module collect_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 64,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             rd,
   output logic [WIDTH-1:0] q,
   output logic             empty,
   output logic [AW:0]      usedw
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             rd_ok;
   logic             wr_ok;

   // A write to a full FIFO is still accepted when a read frees a slot in the same cycle.
   assign rd_ok = rd && (count != '0);
   assign wr_ok = wr && ((count != FULL_CNT) || rd_ok);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign q     = mem[rd_ptr];
   assign empty = (count == '0);
   assign usedw = count;

endmodule

// File: rtl/dispatcher_collect.sv
// Return-path receiver: buffers RDMA packets, forwards kept ones to egress,
// drops flagged ones, and returns each thread's cpuid credit on the head pop.
module dispatcher_collect
   import dispatcher_collect_pkg::*;
#(
   parameter int unsigned PKT_DEPTH     = 256,
   parameter int unsigned VAL_DEPTH     = 64,
   parameter int unsigned PKT_MAX_WORDS = 32,
   parameter int unsigned CPUID_LSB     = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_rdma_pkt_wr,
   input  logic [WORD_W-1:0] in_rdma_pkt,
   input  logic              in_rdma_valid_wr,
   input  logic              in_rdma_valid,
   output logic              out_rdma_pkt_almostfull,
   output logic              out_egress_pkt_wr,
   output logic [WORD_W-1:0] out_egress_pkt,
   output logic              out_egress_valid_wr,
   output logic              out_egress_valid,
   input  logic              in_egress_pkt_almostfull,
   output logic              out_cpuid_release,
   output logic [4:0]        out_cpuid_release_id,
   output logic [31:0]       out_drop_cnt,
   output logic [31:0]       out_err_cnt
);

   localparam int unsigned PAW = $clog2(PKT_DEPTH);
   localparam int unsigned VAW = $clog2(VAL_DEPTH);
   localparam logic [PAW:0] PKT_AF_LEVEL = (PAW+1)'(PKT_DEPTH - PKT_MAX_WORDS);
   localparam logic [VAW:0] VAL_AF_LEVEL = (VAW+1)'(VAL_DEPTH - 2);

   logic [WORD_W-1:0] pkt_q;
   logic              pkt_empty;
   logic [PAW:0]      pkt_usedw;
   logic              pkt_rd;
   logic              val_q;
   logic              val_empty;
   logic [VAW:0]      val_usedw;
   logic              val_rd;

   state_t state;
   state_t state_next;
   logic   first_word;
   logic   tail_pop;
   logic   frame_err;
   logic   fwd_pop;

   collect_fifo #(
      .WIDTH(WORD_W),
      .DEPTH(PKT_DEPTH)
   ) u_pkt_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (in_rdma_pkt_wr),
      .din   (in_rdma_pkt),
      .rd    (pkt_rd),
      .q     (pkt_q),
      .empty (pkt_empty),
      .usedw (pkt_usedw)
   );

   collect_fifo #(
      .WIDTH(1),
      .DEPTH(VAL_DEPTH)
   ) u_val_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (in_rdma_valid_wr),
      .din   (in_rdma_valid),
      .rd    (val_rd),
      .q     (val_q),
      .empty (val_empty),
      .usedw (val_usedw)
   );

   assign out_rdma_pkt_almostfull = (pkt_usedw >= PKT_AF_LEVEL) || (val_usedw >= VAL_AF_LEVEL);

   always_comb begin
      state_next = state;
      pkt_rd     = 1'b0;
      val_rd     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!val_empty) begin
               if (!val_q) begin
                  val_rd     = 1'b1;
                  state_next = ST_DISCARD;
               end else if (!in_egress_pkt_almostfull) begin
                  val_rd     = 1'b1;
                  state_next = ST_FORWARD;
               end
            end
         end
         ST_FORWARD, ST_DISCARD: begin
            if (!pkt_empty) begin
               pkt_rd = 1'b1;
               if (word_type(pkt_q) == TYPE_TAIL) begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign tail_pop  = pkt_rd && (word_type(pkt_q) == TYPE_TAIL);
   assign fwd_pop   = pkt_rd && (state == ST_FORWARD);
   // Misframing is either a non-head opening word or a head appearing mid-packet.
   assign frame_err = pkt_rd && (first_word ? (word_type(pkt_q) != TYPE_HEAD)
                                            : (word_type(pkt_q) == TYPE_HEAD));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         first_word <= 1'b0;
      end else begin
         state <= state_next;
         if (val_rd) begin
            first_word <= 1'b1;
         end else if (pkt_rd) begin
            first_word <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_egress_pkt_wr    <= 1'b0;
         out_egress_pkt       <= '0;
         out_egress_valid_wr  <= 1'b0;
         out_egress_valid     <= 1'b0;
         out_cpuid_release    <= 1'b0;
         out_cpuid_release_id <= '0;
         out_drop_cnt         <= '0;
         out_err_cnt          <= '0;
      end else begin
         out_egress_pkt_wr   <= fwd_pop;
         out_egress_valid_wr <= fwd_pop && tail_pop;
         out_egress_valid    <= fwd_pop && tail_pop;
         out_cpuid_release   <= pkt_rd && first_word;
         if (fwd_pop) begin
            out_egress_pkt <= pkt_q;
         end
         if (pkt_rd && first_word) begin
            out_cpuid_release_id <= pkt_q[CPUID_LSB +: 5];
         end
         if (tail_pop && (state == ST_DISCARD) && (out_drop_cnt != '1)) begin
            out_drop_cnt <= out_drop_cnt + 1'b1;
         end
         if (frame_err && (out_err_cnt != '1)) begin
            out_err_cnt <= out_err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dispatcher_collect.sv
// Bench for dispatcher_collect: directed scenarios plus random packet traffic,
// scored against a packet-level model of what egress and credit return must show.
module tb_dispatcher_collect;
   import dispatcher_collect_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_rdma_pkt_wr = 1'b0;
   logic [133:0] in_rdma_pkt = '0;
   logic         in_rdma_valid_wr = 1'b0;
   logic         in_rdma_valid = 1'b0;
   logic         out_rdma_pkt_almostfull;
   logic         out_egress_pkt_wr;
   logic [133:0] out_egress_pkt;
   logic         out_egress_valid_wr;
   logic         out_egress_valid;
   logic         in_egress_pkt_almostfull = 1'b0;
   logic         out_cpuid_release;
   logic [4:0]   out_cpuid_release_id;
   logic [31:0]  out_drop_cnt;
   logic [31:0]  out_err_cnt;

   dispatcher_collect #(
      .PKT_DEPTH(256),
      .VAL_DEPTH(64),
      .PKT_MAX_WORDS(32),
      .CPUID_LSB(64)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .in_rdma_pkt_wr           (in_rdma_pkt_wr),
      .in_rdma_pkt              (in_rdma_pkt),
      .in_rdma_valid_wr         (in_rdma_valid_wr),
      .in_rdma_valid            (in_rdma_valid),
      .out_rdma_pkt_almostfull  (out_rdma_pkt_almostfull),
      .out_egress_pkt_wr        (out_egress_pkt_wr),
      .out_egress_pkt           (out_egress_pkt),
      .out_egress_valid_wr      (out_egress_valid_wr),
      .out_egress_valid         (out_egress_valid),
      .in_egress_pkt_almostfull (in_egress_pkt_almostfull),
      .out_cpuid_release        (out_cpuid_release),
      .out_cpuid_release_id     (out_cpuid_release_id),
      .out_drop_cnt             (out_drop_cnt),
      .out_err_cnt              (out_err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: words written but not yet claimed by a flag, and what must come out.
   logic [133:0] in_q[$];
   logic [133:0] exp_eg[$];
   logic [4:0]   rel_q[$];
   int unsigned  exp_drop = 0;
   int unsigned  exp_err = 0;
   int           egress_seen = 0;
   int           release_seen = 0;
   bit           rand_af = 1'b0;

   task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // A flag claims every buffered word up to and including the next tail.
   task automatic model_flag(input logic keep);
      logic [133:0] w;
      bit first = 1'b1;
      while (in_q.size() != 0) begin
         w = in_q.pop_front();
         if (first) begin
            rel_q.push_back(w[68:64]);
            if (w[133:132] != TYPE_HEAD) exp_err++;
         end else if (w[133:132] == TYPE_HEAD) begin
            exp_err++;
         end
         first = 1'b0;
         if (keep) exp_eg.push_back(w);
         if (w[133:132] == TYPE_TAIL) break;
      end
      if (!keep) exp_drop++;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (out_egress_pkt_wr) begin
            egress_seen++;
            if (exp_eg.size() == 0) begin
               check("egress_expected", 134'(out_egress_pkt_wr), 134'(0));
            end else begin
               logic [133:0] w;
               w = exp_eg.pop_front();
               check("egress_word", out_egress_pkt, w);
               check("egress_valid_wr", 134'(out_egress_valid_wr), 134'(w[133:132] == TYPE_TAIL));
               check("egress_valid", 134'(out_egress_valid), 134'(w[133:132] == TYPE_TAIL));
            end
         end else begin
            check("egress_valid_idle", 134'({out_egress_valid_wr, out_egress_valid}), 134'(0));
         end
         if (out_cpuid_release) begin
            release_seen++;
            if (rel_q.size() == 0) begin
               check("release_expected", 134'(out_cpuid_release), 134'(0));
            end else begin
               check("release_id", 134'(out_cpuid_release_id), 134'(rel_q.pop_front()));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_af) in_egress_pkt_almostfull = ($urandom_range(0, 3) == 0);
   endtask

   function automatic logic [133:0] mk_word(input logic [1:0] t, input logic [4:0] id);
      logic [159:0] r;
      logic [133:0] w;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      w = r[133:0];
      w[133:132] = t;
      w[68:64] = id;
      return w;
   endfunction

   task automatic wr_word(input logic [133:0] w);
      in_rdma_pkt = w;
      in_rdma_pkt_wr = 1'b1;
      in_q.push_back(w);
      tick();
      in_rdma_pkt_wr = 1'b0;
   endtask

   task automatic wr_flag(input logic v);
      in_rdma_valid = v;
      in_rdma_valid_wr = 1'b1;
      model_flag(v);
      tick();
      in_rdma_valid_wr = 1'b0;
   endtask

   task automatic send_pkt(input int len, input logic [4:0] id, input bit bad_first, input bit bad_mid);
      logic [1:0] t;
      for (int i = 0; i < len; i++) begin
         if (i == len - 1) t = TYPE_TAIL;
         else if (i == 0) t = bad_first ? TYPE_BODY : TYPE_HEAD;
         else t = (bad_mid && i == 1) ? TYPE_HEAD : TYPE_BODY;
         wr_word(mk_word(t, id));
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_eg.size() != 0 || rel_q.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      check("drain_in_time", 134'(n < 3000), 134'(1));
      repeat (40) tick();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (out_rdma_pkt_almostfull && n < 1000) begin
         tick();
         n++;
      end
      check("ready_in_time", 134'(n < 1000), 134'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int e0;
      int r0;
      int cnt;
      int n;

      repeat (3) @(posedge clk);
      #1;
      check("reset_egress_wr", 134'(out_egress_pkt_wr), 134'(0));
      check("reset_egress_pkt", out_egress_pkt, 134'(0));
      check("reset_release", 134'(out_cpuid_release), 134'(0));
      check("reset_almostfull", 134'(out_rdma_pkt_almostfull), 134'(0));
      check("reset_drop_cnt", 134'(out_drop_cnt), 134'(0));
      check("reset_err_cnt", 134'(out_err_cnt), 134'(0));
      reset = 1'b1;
      tick();

      // Keep packet with exact latency from flag write to first egress word.
      e0 = egress_seen;
      r0 = release_seen;
      send_pkt(4, 5'd7, 1'b0, 1'b0);
      in_rdma_valid = 1'b1;
      in_rdma_valid_wr = 1'b1;
      model_flag(1'b1);
      tick();
      in_rdma_valid_wr = 1'b0;
      @(negedge clk);
      check("lat_n1_wr", 134'(out_egress_pkt_wr), 134'(0));
      @(negedge clk);
      check("lat_n2_wr", 134'(out_egress_pkt_wr), 134'(0));
      @(negedge clk);
      check("lat_n3_wr", 134'(out_egress_pkt_wr), 134'(1));
      check("lat_n3_release", 134'(out_cpuid_release), 134'(1));
      check("lat_n3_release_id", 134'(out_cpuid_release_id), 134'(7));
      #2;
      wait_drain();
      check("keep_words", 134'(egress_seen - e0), 134'(4));
      check("keep_releases", 134'(release_seen - r0), 134'(1));

      // Dropped packet.
      e0 = egress_seen;
      r0 = release_seen;
      send_pkt(3, 5'd3, 1'b0, 1'b0);
      wr_flag(1'b0);
      wait_drain();
      check("drop_words", 134'(egress_seen - e0), 134'(0));
      check("drop_releases", 134'(release_seen - r0), 134'(1));
      check("drop_cnt_1", 134'(out_drop_cnt), 134'(1));

      // Egress backpressure holds a kept packet in IDLE, but not mid-packet.
      e0 = egress_seen;
      in_egress_pkt_almostfull = 1'b1;
      send_pkt(5, 5'd9, 1'b0, 1'b0);
      wr_flag(1'b1);
      repeat (10) tick();
      check("bp_no_pop", 134'(egress_seen - e0), 134'(0));
      in_egress_pkt_almostfull = 1'b0;
      n = 0;
      while (egress_seen == e0 && n < 50) begin
         tick();
         n++;
      end
      in_egress_pkt_almostfull = 1'b1;
      wait_drain();
      in_egress_pkt_almostfull = 1'b0;
      check("bp_words", 134'(egress_seen - e0), 134'(5));

      // Framing error: head, head, tail.
      e0 = egress_seen;
      r0 = release_seen;
      wr_word(mk_word(TYPE_HEAD, 5'd4));
      wr_word(mk_word(TYPE_HEAD, 5'd4));
      wr_word(mk_word(TYPE_TAIL, 5'd4));
      wr_flag(1'b1);
      wait_drain();
      check("frame_err_cnt", 134'(out_err_cnt), 134'(1));
      check("frame_words", 134'(egress_seen - e0), 134'(3));
      check("frame_releases", 134'(release_seen - r0), 134'(1));

      // Input almostfull threshold at 224 buffered words.
      in_egress_pkt_almostfull = 1'b1;
      cnt = 0;
      for (int p = 0; p < 7; p++) begin
         for (int i = 0; i < 32; i++) begin
            wr_word(mk_word(i == 0 ? TYPE_HEAD : (i == 31 ? TYPE_TAIL : TYPE_BODY), 5'(p)));
            cnt++;
            if (cnt == 223) check("af_at_223", 134'(out_rdma_pkt_almostfull), 134'(0));
            if (cnt == 224) check("af_at_224", 134'(out_rdma_pkt_almostfull), 134'(1));
         end
      end
      for (int p = 0; p < 7; p++) wr_flag(1'b1);
      check("af_held", 134'(out_rdma_pkt_almostfull), 134'(1));
      in_egress_pkt_almostfull = 1'b0;
      n = 0;
      while (out_rdma_pkt_almostfull && n < 100) begin
         tick();
         n++;
      end
      check("af_released", 134'(out_rdma_pkt_almostfull), 134'(0));
      wait_drain();

      // Reset in the middle of a forwarded packet.
      e0 = egress_seen;
      send_pkt(8, 5'd12, 1'b0, 1'b0);
      wr_flag(1'b1);
      n = 0;
      while (egress_seen == e0 && n < 50) begin
         tick();
         n++;
      end
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("rst_egress_wr", 134'(out_egress_pkt_wr), 134'(0));
      check("rst_egress_pkt", out_egress_pkt, 134'(0));
      check("rst_valid", 134'({out_egress_valid_wr, out_egress_valid}), 134'(0));
      check("rst_release", 134'({out_cpuid_release, out_cpuid_release_id}), 134'(0));
      check("rst_cnts", 134'({out_drop_cnt, out_err_cnt}), 134'(0));
      in_q.delete();
      exp_eg.delete();
      rel_q.delete();
      exp_drop = 0;
      exp_err = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      e0 = egress_seen;
      send_pkt(4, 5'd21, 1'b0, 1'b0);
      wr_flag(1'b1);
      wait_drain();
      check("post_rst_words", 134'(egress_seen - e0), 134'(4));
      check("post_rst_err", 134'(out_err_cnt), 134'(0));

      // Random traffic with random egress backpressure.
      rand_af = 1'b1;
      for (int p = 0; p < 60; p++) begin
         wait_ready();
         send_pkt($urandom_range(1, 8), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
         repeat ($urandom_range(0, 2)) tick();
         wr_flag($urandom_range(0, 3) != 0);
      end
      rand_af = 1'b0;
      in_egress_pkt_almostfull = 1'b0;
      wait_drain();
      check("final_drop_cnt", 134'(out_drop_cnt), 134'(exp_drop));
      check("final_err_cnt", 134'(out_err_cnt), 134'(exp_err));
      check("final_leftover_words", 134'(in_q.size()), 134'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
